// File: rtl/half_adder_sync.sv
// half_adder_sync: WIDTH independent half-adder lanes (s = a ^ b, c = a & b)
// with an optional output register stage and a valid strobe.
// REG_OUT = 1 registers s/c/out_valid (1-cycle latency, full throughput).
// REG_OUT = 0 drives them combinationally, forced to zero while rst is high.
// Optional feature macro: HALF_ADDER_STATS_EN adds the 32-bit carry_cnt port,
// a saturating count of accepted operand sets that produced any carry.
module half_adder_sync #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
`ifdef HALF_ADDER_STATS_EN
    output logic [31:0]      carry_cnt,
`endif
    output logic             out_valid
);

    // Per-lane half-add results; lanes never interact.
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign sum_next[gi]   = a[gi] ^ b[gi];
            assign carry_next[gi] = a[gi] & b[gi];
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] s_reg;
            logic [WIDTH-1:0] c_reg;
            logic             out_valid_reg;

            // Capture results only on valid operands so idle (possibly X)
            // inputs never disturb the held s/c; reset wins over in_valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_reg         <= '0;
                    c_reg         <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= in_valid;
                    if (in_valid) begin
                        s_reg <= sum_next;
                        c_reg <= carry_next;
                    end
                end
            end

            assign s         = s_reg;
            assign c         = c_reg;
            assign out_valid = out_valid_reg;
        end else begin : g_comb
            // Zero-latency path; reset masks the outputs to zero.
            assign s         = rst ? '0 : sum_next;
            assign c         = rst ? '0 : carry_next;
            assign out_valid = in_valid & ~rst;
        end
    endgenerate

`ifdef HALF_ADDER_STATS_EN
    logic [31:0] carry_cnt_reg;
    logic        carry_seen;

    assign carry_seen = |carry_next;

    // Count accepted operand sets with any carry, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt_reg <= 32'd0;
        end else if (in_valid && carry_seen && (carry_cnt_reg != 32'hFFFF_FFFF)) begin
            carry_cnt_reg <= carry_cnt_reg + 32'd1;
        end
    end

    assign carry_cnt = carry_cnt_reg;
`endif

endmodule

// File: tb/tb_half_adder_sync.sv
// Self-checking bench for half_adder_sync: a registered 8-lane instance plus a
// combinational 4-lane instance sharing the same stimulus.
module tb_half_adder_sync;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         out_valid;
    logic [3:0]   s_comb;
    logic [3:0]   c_comb;
    logic         out_valid_comb;
`ifdef HALF_ADDER_STATS_EN
    logic [31:0]  carry_cnt;
    logic [31:0]  carry_cnt_comb;
`endif

    int checks;
    int failures;

    half_adder_sync #(.WIDTH(W), .REG_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .s         (s),
        .c         (c),
`ifdef HALF_ADDER_STATS_EN
        .carry_cnt (carry_cnt),
`endif
        .out_valid (out_valid)
    );

    half_adder_sync #(.WIDTH(4), .REG_OUT(1'b0)) dut_comb (
        .clk       (clk),
        .rst       (rst),
        .a         (a[3:0]),
        .b         (b[3:0]),
        .in_valid  (in_valid),
        .s         (s_comb),
        .c         (c_comb),
`ifdef HALF_ADDER_STATS_EN
        .carry_cnt (carry_cnt_comb),
`endif
        .out_valid (out_valid_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic v);
        a        = av;
        b        = bv;
        in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (s !== 8'h00 || c !== 8'h00 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_reg cyc=%0d got s=%h c=%h ov=%b want s=00 c=00 ov=0", i, s, c, out_valid);
            end
            checks++;
            if (s_comb !== 4'h0 || c_comb !== 4'h0 || out_valid_comb !== 1'b0) begin
                failures++;
                $display("FAIL reset_comb cyc=%0d got s=%h c=%h ov=%b want s=0 c=0 ov=0", i, s_comb, c_comb, out_valid_comb);
            end
            $display("reset cyc=%0d s=%h c=%h ov=%b", i, s, c, out_valid);
        end
        rst = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        step();
    endtask

    // Truth table on lane 0, consecutive cycles (back-to-back valids).
    task automatic test_exhaustive();
        logic [1:0] ab_tbl [4];
        logic [1:0] sc_tbl [4];
        ab_tbl = '{2'b00, 2'b01, 2'b10, 2'b11};
        sc_tbl = '{2'b00, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive({7'd0, ab_tbl[i][1]}, {7'd0, ab_tbl[i][0]}, 1'b1);
            step();
            checks++;
            if ({s[0], c[0]} !== sc_tbl[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL exhaustive ab=%b got sc=%b%b ov=%b want sc=%b ov=1", ab_tbl[i], s[0], c[0], out_valid, sc_tbl[i]);
            end
            $display("exhaustive ab=%b sc=%b%b ov=%b", ab_tbl[i], s[0], c[0], out_valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        void'($urandom(4045));
        drive(8'hA5, 8'h3C, 1'b1);
        step();
        checks++;
        if (s !== 8'h99 || c !== 8'h24 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL example a=A5 b=3C got s=%h c=%h ov=%b want s=99 c=24 ov=1", s, c, out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            av = W'($urandom_range(255, 0));
            bv = W'($urandom_range(255, 0));
            drive(av, bv, 1'b1);
            step();
            checks++;
            if (s !== (av ^ bv) || c !== (av & bv) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL random a=%h b=%h got s=%h c=%h ov=%b want s=%h c=%h ov=1", av, bv, s, c, out_valid, av ^ bv, av & bv);
            end
            $display("random a=%h b=%h s=%h c=%h", av, bv, s, c);
        end
    endtask

    task automatic test_hold();
        drive(8'h01, 8'h01, 1'b1);
        step();
        checks++;
        if (s !== 8'h00 || c !== 8'h01 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_load got s=%h c=%h ov=%b want s=00 c=01 ov=1", s, c, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive('x, 8'h5A, 1'b0);
            else        drive(8'hFF - 8'(i), 8'h0F, 1'b0);
            step();
            checks++;
            if (s !== 8'h00 || c !== 8'h01 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold cyc=%0d got s=%h c=%h ov=%b want s=00 c=01 ov=0", i, s, c, out_valid);
            end
            $display("hold cyc=%0d s=%h c=%h ov=%b", i, s, c, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        drive(8'h0F, 8'hF0, 1'b1);
        step();
        checks++;
        if (s !== 8'hFF || c !== 8'h00 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got s=%h c=%h ov=%b want s=FF c=00 ov=1", s, c, out_valid);
        end
        rst = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1);
        step();
        checks++;
        if (s !== 8'h00 || c !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got s=%h c=%h ov=%b want s=00 c=00 ov=0", s, c, out_valid);
        end
        rst = 1'b0;
        drive(8'h33, 8'h11, 1'b1);
        step();
        checks++;
        if (s !== 8'h22 || c !== 8'h11 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_resume got s=%h c=%h ov=%b want s=22 c=11 ov=1", s, c, out_valid);
        end
        $display("midstream resume s=%h c=%h ov=%b", s, c, out_valid);
    endtask

    task automatic test_comb();
        drive(8'h0A, 8'h06, 1'b1);
        #1;
        checks++;
        if (s_comb !== 4'hC || c_comb !== 4'h2 || out_valid_comb !== 1'b1) begin
            failures++;
            $display("FAIL comb_valid got s=%h c=%h ov=%b want s=C c=2 ov=1", s_comb, c_comb, out_valid_comb);
        end
        drive(8'h0F, 8'h03, 1'b0);
        #1;
        checks++;
        if (s_comb !== 4'hC || c_comb !== 4'h3 || out_valid_comb !== 1'b0) begin
            failures++;
            $display("FAIL comb_idle got s=%h c=%h ov=%b want s=C c=3 ov=0", s_comb, c_comb, out_valid_comb);
        end
        rst = 1'b1;
        drive(8'h0F, 8'h0F, 1'b1);
        #1;
        checks++;
        if (s_comb !== 4'h0 || c_comb !== 4'h0 || out_valid_comb !== 1'b0) begin
            failures++;
            $display("FAIL comb_rst got s=%h c=%h ov=%b want s=0 c=0 ov=0", s_comb, c_comb, out_valid_comb);
        end
        $display("comb s=%h c=%h ov=%b", s_comb, c_comb, out_valid_comb);
        step();
        rst = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        step();
    endtask

`ifdef HALF_ADDER_STATS_EN
    task automatic test_stats();
        logic [3:0] av_tbl [4];
        logic [3:0] bv_tbl [4];
        av_tbl = '{4'h1, 4'h1, 4'hF, 4'h8};
        bv_tbl = '{4'h1, 4'h2, 4'h0, 4'h8};
        rst = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        checks++;
        if (carry_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset got cnt=%h want 0", carry_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive({4'h0, av_tbl[i]}, {4'h0, bv_tbl[i]}, 1'b1);
            step();
        end
        drive(8'h00, 8'h00, 1'b0);
        checks++;
        if (carry_cnt !== 32'd2) begin
            failures++;
            $display("FAIL stats_count got cnt=%h want 2", carry_cnt);
        end
        $display("stats cnt=%0d", carry_cnt);
        dut.carry_cnt_reg = 32'hFFFF_FFFE;
        drive(8'h01, 8'h01, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (carry_cnt !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL stats_sat cyc=%0d got cnt=%h want FFFFFFFF", i, carry_cnt);
            end
        end
        drive(8'h00, 8'h00, 1'b0);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        test_reset();
        test_exhaustive();
        test_random();
        test_hold();
        test_reset_midstream();
        test_comb();
`ifdef HALF_ADDER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
